frame_scheduler: RTL and testbench

- Sequences once-per-frame game-state updates against the VGA timing generator.
- Detects the start of vertical sync and requests new object positions from the game logic over a 4-phase req/ack handshake.
- Commits the positions to shadow registers, so the pixel renderer sees positions that stay stable across a whole active frame.
- Sits between the VGA timing generator, the game logic and the pixel renderer.

---
 rtl/frame_scheduler.sv | 90 +++++++++
 tb/tb_frame_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame req/ack position update sequenced on vSync, committed to renderer shadows
module frame_scheduler #(
  parameter int UPDATE_DIV = 1,
  parameter int W          = 12,
  parameter int FC_W       = 16,
  parameter int BALL_X0    = 400,
  parameter int BALL_Y0    = 300,
  parameter int PAD_Y0     = 260
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            blank_n,
  input  logic            vSync_n,
  input  logic            pause,
  input  logic            updAck,
  input  logic [W-1:0]    ballXIn,
  input  logic [W-1:0]    ballYIn,
  input  logic [W-1:0]    padLIn,
  input  logic [W-1:0]    padRIn,
  output logic            updReq,
  output logic            frameTick,
  output logic [FC_W-1:0] frameCount,
  output logic [7:0]      missCount,
  output logic [W-1:0]    ballX,
  output logic [W-1:0]    ballY,
  output logic [W-1:0]    padL,
  output logic [W-1:0]    padR
);
  typedef enum logic [1:0] {IDLE, REQ, ACKLOW} state_t;
  state_t state_q, state_d;
  logic vs_q, vs_edge, upd_frame, cap, drop;
  logic req_q, req_d, tick_q, tick_d;
  logic [7:0] div_q, div_d, miss_q, miss_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [W-1:0] bx_q, bx_d, by_q, by_d, pl_q, pl_d, pr_q, pr_d;
  always_comb begin
    vs_edge   = vs_q & ~vSync_n;
    upd_frame = vs_edge & ~pause & (div_q == 8'(UPDATE_DIV - 1));
    div_d     = (vs_edge & ~pause) ? (upd_frame ? 8'd0 : div_q + 8'd1) : div_q;
    fc_d      = fc_q + FC_W'(vs_edge);
    tick_d    = vs_edge;
    cap       = (state_q == REQ) & updAck;
    drop      = (state_q == REQ) & ~updAck & blank_n;
    // ack beats a simultaneous return to active video
    state_d   = (state_q == IDLE) ? (upd_frame ? REQ : IDLE) :
                (state_q == REQ)  ? (updAck ? ACKLOW : (blank_n ? IDLE : REQ)) :
                                    (updAck ? ACKLOW : IDLE);
    req_d     = (state_d == REQ);
    miss_d    = miss_q + 8'(drop & (miss_q != 8'hff));
    bx_d      = cap ? ballXIn : bx_q;
    by_d      = cap ? ballYIn : by_q;
    pl_d      = cap ? padLIn  : pl_q;
    pr_d      = cap ? padRIn  : pr_q;
  end
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      vs_q    <= 1'b1;
      req_q   <= 1'b0;
      tick_q  <= 1'b0;
      div_q   <= '0;
      fc_q    <= '0;
      miss_q  <= '0;
      bx_q    <= W'(BALL_X0);
      by_q    <= W'(BALL_Y0);
      pl_q    <= W'(PAD_Y0);
      pr_q    <= W'(PAD_Y0);
    end else begin
      state_q <= state_d;
      vs_q    <= vSync_n;
      req_q   <= req_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      fc_q    <= fc_d;
      miss_q  <= miss_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
    end
  end
  assign updReq     = req_q;
  assign frameTick  = tick_q;
  assign frameCount = fc_q;
  assign missCount  = miss_q;
  assign ballX      = bx_q;
  assign ballY      = by_q;
  assign padL       = pl_q;
  assign padR       = pr_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: two instances (divide-by-1 with 8-bit frame counter, divide-by-3) against a rule-based model
module tb_frame_scheduler;
  logic clk = 1'b0;
  logic rst_n, blank_n, vSync_n, pause, updAck;
  logic [11:0] ballXIn, ballYIn, padLIn, padRIn;
  logic updReq1, frameTick1, updReq3, frameTick3;
  logic [7:0] frameCount1, missCount1, missCount3;
  logic [15:0] frameCount3;
  logic [11:0] ballX1, ballY1, padL1, padR1, ballX3, ballY3, padL3, padR3;
  int checks = 0, errors = 0;
  int m_fc[2], m_div[2], m_miss[2], m_ph[2], m_bx[2], m_by[2], m_pl[2], m_pr[2];
  bit m_vsn[2], m_tick[2];
  int ack_mode = 3, ack_dly = 0, req_cnt = 0;
  bit stuck = 0, fixed_data = 0, rnd_pause = 0, prev_req1 = 0, prev_req3 = 0;
  int rises1 = 0, rises3 = 0, ticks1 = 0;
  always #5 clk = ~clk;
  frame_scheduler #(.UPDATE_DIV(1), .FC_W(8)) u1 (
    .Clock(clk), .Reset_n(rst_n), .blank_n(blank_n), .vSync_n(vSync_n), .pause(pause),
    .updAck(updAck), .ballXIn(ballXIn), .ballYIn(ballYIn), .padLIn(padLIn), .padRIn(padRIn),
    .updReq(updReq1), .frameTick(frameTick1), .frameCount(frameCount1), .missCount(missCount1),
    .ballX(ballX1), .ballY(ballY1), .padL(padL1), .padR(padR1));
  frame_scheduler #(.UPDATE_DIV(3)) u3 (
    .Clock(clk), .Reset_n(rst_n), .blank_n(blank_n), .vSync_n(vSync_n), .pause(pause),
    .updAck(updAck), .ballXIn(ballXIn), .ballYIn(ballYIn), .padLIn(padLIn), .padRIn(padRIn),
    .updReq(updReq3), .frameTick(frameTick3), .frameCount(frameCount3), .missCount(missCount3),
    .ballX(ballX3), .ballY(ballY3), .padL(padL3), .padR(padR3));
  function automatic int div_of(int k); return k == 0 ? 1 : 3; endfunction
  function automatic int fc_mod(int k); return k == 0 ? 256 : 65536; endfunction
  // phases: 0 waiting for an update frame, 1 request outstanding, 2 waiting for ack release
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_vsn[k] <= 1; m_tick[k] <= 0; m_fc[k] <= 0; m_div[k] <= 0; m_miss[k] <= 0; m_ph[k] <= 0;
        m_bx[k] <= 400; m_by[k] <= 300; m_pl[k] <= 260; m_pr[k] <= 260;
      end else begin
        m_vsn[k] <= vSync_n;
        m_tick[k] <= m_vsn[k] && !vSync_n;
        if (m_vsn[k] && !vSync_n) begin
          m_fc[k] <= (m_fc[k] + 1) % fc_mod(k);
          if (!pause) m_div[k] <= (m_div[k] + 1) % div_of(k);
        end
        if (m_ph[k] == 0 && m_vsn[k] && !vSync_n && !pause && (m_div[k] + 1) % div_of(k) == 0)
          m_ph[k] <= 1;
        else if (m_ph[k] == 1 && updAck) begin
          m_ph[k] <= 2;
          m_bx[k] <= ballXIn; m_by[k] <= ballYIn; m_pl[k] <= padLIn; m_pr[k] <= padRIn;
        end else if (m_ph[k] == 1 && blank_n) begin
          m_ph[k] <= 0;
          m_miss[k] <= m_miss[k] < 255 ? m_miss[k] + 1 : 255;
        end else if (m_ph[k] == 2 && !updAck)
          m_ph[k] <= 0;
      end
    end
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    if (m_ph[0] != 1) req_cnt = 0;
    if (ack_mode inside {1, 2} && m_ph[0] == 1 && !updAck) begin
      if (req_cnt >= ack_dly) begin
        updAck = 1;
        if (ack_mode == 2) stuck = 1;
        if (fixed_data) begin ballXIn = 123; ballYIn = 45; padLIn = 10; padRIn = 500; end
      end else req_cnt++;
    end else if (ack_mode != 3 && updAck && m_ph[0] != 1 && !stuck) updAck = 0;
    if (!updAck) begin
      ballXIn = 12'($urandom); ballYIn = 12'($urandom); padLIn = 12'($urandom); padRIn = 12'($urandom);
    end
    if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    chk("tick1", frameTick1, m_tick[0]);   chk("tick3", frameTick3, m_tick[1]);
    chk("req1", updReq1, m_ph[0] == 1);    chk("req3", updReq3, m_ph[1] == 1);
    chk("fc1", frameCount1, m_fc[0]);      chk("fc3", frameCount3, m_fc[1]);
    chk("miss1", missCount1, m_miss[0]);   chk("miss3", missCount3, m_miss[1]);
    chk("ballX1", ballX1, m_bx[0]);        chk("ballX3", ballX3, m_bx[1]);
    chk("ballY1", ballY1, m_by[0]);        chk("ballY3", ballY3, m_by[1]);
    chk("padL1", padL1, m_pl[0]);          chk("padL3", padL3, m_pl[1]);
    chk("padR1", padR1, m_pr[0]);          chk("padR3", padR3, m_pr[1]);
    if (updReq1 && !prev_req1) rises1++;
    if (updReq3 && !prev_req3) rises3++;
    if (frameTick1) ticks1++;
    prev_req1 = updReq1; prev_req3 = updReq3;
  endtask
  task automatic frame(input int a, input int v, input int b);
    repeat (a) begin blank_n = 1; vSync_n = 1; step(); end
    repeat (v) begin blank_n = 0; vSync_n = 0; step(); end
    repeat (b) begin blank_n = 0; vSync_n = 1; step(); end
  endtask
  task automatic do_reset();
    updAck = 0; stuck = 0; rst_n = 0;
    repeat (3) step();
    rst_n = 1;
  endtask
  initial begin
    rst_n = 0; blank_n = 1; vSync_n = 1; pause = 0; updAck = 0;
    ballXIn = 0; ballYIn = 0; padLIn = 0; padRIn = 0;
    repeat (3) step();
    rst_n = 1;
    frame(2, 1, 1);
    chk("midreq", updReq1, 1);
    do_reset();
    chk("rst_req", updReq1, 0); chk("rst_bx", ballX1, 400); chk("rst_by", ballY1, 300);
    chk("rst_pl", padL1, 260);  chk("rst_pr", padR1, 260);  chk("rst_fc", frameCount1, 0);
    chk("rst_miss", missCount1, 0);
    ack_mode = 1; ack_dly = 5; fixed_data = 1;
    frame(4, 2, 12);
    fixed_data = 0;
    chk("upd_bx", ballX1, 123); chk("upd_by", ballY1, 45);
    chk("upd_pl", padL1, 10);   chk("upd_pr", padR1, 500);
    ack_mode = 0;
    repeat (300) frame(2, 1, 2);
    chk("miss_sat", missCount1, 255);
    ack_mode = 3;
    do_reset();
    frame(1, 1, 2);
    chk("sim_req", updReq1, 1);
    blank_n = 1; vSync_n = 1; updAck = 1;
    ballXIn = 777; ballYIn = 66; padLIn = 55; padRIn = 44;
    step();
    chk("sim_bx", ballX1, 777); chk("sim_miss", missCount1, 0);
    updAck = 0;
    step(); step();
    do_reset();
    ack_mode = 1; ack_dly = 0; rises3 = 0;
    repeat (6) frame(3, 1, 6);
    chk("div_req", rises3, 2); chk("div_fc", frameCount3, 6);
    pause = 1;
    repeat (4) frame(3, 1, 6);
    pause = 0;
    chk("pause_req", rises3, 2); chk("pause_fc", frameCount3, 10);
    repeat (3) frame(3, 1, 6);
    chk("frozen_req", rises3, 3);
    rnd_pause = 1;
    for (int f = 0; f < 150; f++) begin
      ack_mode = $urandom_range(0, 2); ack_dly = $urandom_range(0, 6);
      if (ack_mode != 2) stuck = 0;
      frame($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(0, 8));
    end
    rnd_pause = 0; pause = 0; stuck = 0; ack_mode = 0;
    do_reset();
    repeat (255) frame(1, 1, 1);
    chk("pre_wrap", frameCount1, 255);
    frame(1, 1, 1);
    chk("wrap", frameCount1, 0);
    ack_mode = 2; ack_dly = 1;
    frame(2, 1, 4);
    chk("stuck_ack", updAck, 1);
    rises1 = 0; ticks1 = 0;
    frame(2, 1, 3);
    chk("stuck_noreq", rises1, 0); chk("stuck_tick", ticks1, 1);
    ack_mode = 1; stuck = 0;
    repeat (3) frame(2, 1, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
